mem_port_arbiter: RTL and testbench

//  Shares the single 2 KiB data/instruction memory port between the fetch unit (IF) and the load/store unit (LS).
//  - Per-requester valid/ready handshakes.
//  - Drives issue-stage controls (address, offset address, write data, write enable, byte/half enables).
//  - Registers response-stage controls (size, sign-extend) one cycle later; the memory's read data lands in that cycle.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_grant.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_pkg: shared types, sizes and helpers for the memory port arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    LS   = 2'd2
  } owner_e;

  localparam int MEM_BYTES = 2048;

  // Byte 1 is live for HALF and WORD accesses, the upper half only for WORD.
  // Returned as {upper, byte1}.
  function automatic logic [1:0] size_to_enables(input size_e size);
    return {size == WORD, size != BYTE};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes, memory issue controls and
// response-stage controls of the shared memory port.
interface mem_port_arbiter_if;
  import mem_pkg::*;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_req_addr;
  logic        ls_req_we;
  logic [31:0] ls_req_wdata;
  size_e       ls_req_size;
  logic        ls_req_sext;
  logic        mem_clk_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_offset_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_byte1_en;
  logic        mem_upper_en;
  logic        rsp_byte1_en;
  logic        rsp_upper_en;
  logic        rsp_sext;
  logic        if_rsp_valid;
  logic        ls_rsp_valid;
  logic        rsp_err;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_req_addr,
    input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_size, ls_req_sext,
    output if_req_ready, ls_req_ready,
    output mem_clk_enable, mem_addr, mem_offset_addr, mem_wdata, mem_we,
    output mem_byte1_en, mem_upper_en,
    output rsp_byte1_en, rsp_upper_en, rsp_sext, if_rsp_valid, ls_rsp_valid, rsp_err
  );

  // Requester / memory side
  modport master (
    output if_req_valid, if_req_addr,
    output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_size, ls_req_sext,
    input  if_req_ready, ls_req_ready,
    input  mem_clk_enable, mem_addr, mem_offset_addr, mem_wdata, mem_we,
    input  mem_byte1_en, mem_upper_en,
    input  rsp_byte1_en, rsp_upper_en, rsp_sext, if_rsp_valid, ls_rsp_valid, rsp_err
  );

endinterface

// File: rtl/mem_port_arbiter_grant.sv
// mem_arb_grant: turns the two request valids into a one-hot grant.
// LS has priority; with MEM_ARB_FAIRNESS_EN defined, a saturating counter of
// LS grants taken while IF waits forces IF through once it hits STARVE_LIMIT.
module mem_arb_grant
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ifValid_i,
  input  logic lsValid_i,
  output logic ifGnt_o,
  output logic lsGnt_o
);

  logic forceIf;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [2:0] starveCnt_q;
  logic [2:0] starveCnt_d;

  assign forceIf = (starveCnt_q == 3'(STARVE_LIMIT));

  // Count LS grants that kept a waiting IF out; any IF grant or IF going idle restarts the count
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!ifValid_i || ifGnt_o) begin
      starveCnt_d = '0;
    end else if (lsGnt_o && (starveCnt_q != 3'd7)) begin
      starveCnt_d = starveCnt_q + 3'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  logic unusedFairness;

  // Strict LS priority; clk and the limit are only tied off so they stay referenced
  assign forceIf        = 1'b0;
  assign unusedFairness = clk ^ (STARVE_LIMIT != 0);
`endif

  // Nothing is granted while reset is asserted, so all outputs read as zero
  assign lsGnt_o = rst_n & lsValid_i & ~(forceIf & ifValid_i);
  assign ifGnt_o = rst_n & ifValid_i & ~lsGnt_o;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single 2 KiB memory port between instruction
// fetch (IF) and load/store (LS). Issue controls are driven in the grant cycle,
// response controls are registered for the following cycle when read data lands.
// Optional fairness: define MEM_ARB_FAIRNESS_EN (see mem_arb_grant).
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_BITS    = $clog2(MEM_BYTES),
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  logic        ifGnt;
  logic        lsGnt;
  logic        issue;

  logic [31:0] selAddr;
  logic [31:0] selWdata;
  size_e       selSize;
  logic        selWe;
  logic        selSext;
  logic [1:0]  selEn;
  logic        inRange;
  logic        respond;

  logic [31:0] addr_q,   addr_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] wdata_q,  wdata_d;
  logic        byte1_q,  byte1_d;
  logic        upper_q,  upper_d;

  owner_e      owner_q,    owner_d;
  logic        rspByte1_q, rspByte1_d;
  logic        rspUpper_q, rspUpper_d;
  logic        rspSext_q,  rspSext_d;
  logic        rspErr_q,   rspErr_d;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .rst_n    (rst_n),
    .ifValid_i(bus.if_req_valid),
    .lsValid_i(bus.ls_req_valid),
    .ifGnt_o  (ifGnt),
    .lsGnt_o  (lsGnt)
  );

  assign issue            = ifGnt | lsGnt;
  assign bus.if_req_ready = ifGnt;
  assign bus.ls_req_ready = lsGnt;

  // Steer the winner onto the issue stage; IF is always a plain word read
  always_comb begin
    selAddr  = bus.if_req_addr;
    selWdata = '0;
    selSize  = WORD;
    selWe    = 1'b0;
    selSext  = 1'b0;
    if (lsGnt) begin
      selAddr  = bus.ls_req_addr;
      selWdata = bus.ls_req_wdata;
      selSize  = bus.ls_req_size;
      selWe    = bus.ls_req_we;
      selSext  = bus.ls_req_sext;
    end
    selEn   = size_to_enables(selSize);
    inRange = (selAddr[31:ADDR_BITS] == '0);
    // Reads always answer; stores only answer to report an out-of-range address
    respond = ifGnt | (lsGnt & (~selWe | ~inRange));
  end

  // Issue-stage values: follow the winner on a grant, otherwise hold the last issue
  always_comb begin
    addr_d   = addr_q;
    offset_d = offset_q;
    wdata_d  = wdata_q;
    byte1_d  = byte1_q;
    upper_d  = upper_q;
    if (issue) begin
      addr_d   = selAddr;
      offset_d = selAddr + 32'd4;
      wdata_d  = selWdata;
      byte1_d  = selEn[0];
      upper_d  = selEn[1];
    end
  end

  // Next response-stage owner and controls, zero when no response is due
  always_comb begin
    owner_d = NONE;
    if (ifGnt) begin
      owner_d = IF;
    end else if (respond) begin
      owner_d = LS;
    end
    rspByte1_d = respond & selEn[0];
    rspUpper_d = respond & selEn[1];
    rspSext_d  = respond & selSext;
    rspErr_d   = respond & ~inRange;
  end

  // Hold registers for the issue stage and the one-deep response pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      offset_q   <= '0;
      wdata_q    <= '0;
      byte1_q    <= 1'b0;
      upper_q    <= 1'b0;
      owner_q    <= NONE;
      rspByte1_q <= 1'b0;
      rspUpper_q <= 1'b0;
      rspSext_q  <= 1'b0;
      rspErr_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      offset_q   <= offset_d;
      wdata_q    <= wdata_d;
      byte1_q    <= byte1_d;
      upper_q    <= upper_d;
      owner_q    <= owner_d;
      rspByte1_q <= rspByte1_d;
      rspUpper_q <= rspUpper_d;
      rspSext_q  <= rspSext_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign bus.mem_clk_enable  = issue;
  assign bus.mem_addr        = addr_d;
  assign bus.mem_offset_addr = offset_d;
  assign bus.mem_wdata       = wdata_d;
  assign bus.mem_we          = issue & selWe & inRange;
  assign bus.mem_byte1_en    = byte1_d;
  assign bus.mem_upper_en    = upper_d;

  assign bus.if_rsp_valid    = (owner_q == IF);
  assign bus.ls_rsp_valid    = (owner_q == LS);
  assign bus.rsp_byte1_en    = rspByte1_q;
  assign bus.rsp_upper_en    = rspUpper_q;
  assign bus.rsp_sext        = rspSext_q;
  assign bus.rsp_err         = rspErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random requests against a cycle-level
// reference model; expectations go into queues that a monitor drains.
// Honours MEM_ARB_FAIRNESS_EN the same way the design does.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int STARVE   = 4;
  localparam int MEM_SIZE = 2048;

  typedef struct {
    bit          ifRdy;
    bit          lsRdy;
    bit          clkEn;
    bit          we;
    bit          byte1;
    bit          upper;
    logic [31:0] addr;
    logic [31:0] offset;
    logic [31:0] wdata;
    bit          chkWdata;
    bit          rspZero;
  } issue_t;

  typedef struct {
    int cycle;
    bit isIf;
    bit byte1;
    bit upper;
    bit sext;
    bit err;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  issue_t issueQ[$];
  rsp_t   rspQ[$];
  int     total    = 0;
  int     bad      = 0;
  int     drvCycle = 0;

  // reference model state
  logic [31:0] lastAddr   = '0;
  logic [31:0] lastOffset = '0;
  logic [31:0] lastWdata  = '0;
  bit          lastByte1  = 1'b0;
  bit          lastUpper  = 1'b0;
  bit          sinceReset = 1'b1;
`ifdef MEM_ARB_FAIRNESS_EN
  int          starve     = 0;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .ADDR_BITS   (11),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, drvCycle, act, exp);
    end
  endtask

  // Drive one cycle of requests at the falling edge and record what must come out
  task automatic applyStimulus(input bit rstLow, input bit ifV, input logic [31:0] ifA,
                               input bit lsV, input logic [31:0] lsA, input bit lsWe,
                               input logic [31:0] lsWd, input int lsSize, input bit lsSext);
    issue_t      e;
    rsp_t        r;
    bit          forced;
    bit          gIf;
    bit          gLs;
    bit          inRange;
    int          size;
    logic [31:0] a;
    @(negedge clk);
    drvCycle++;
    rst_n            = !rstLow;
    bus.if_req_valid = ifV;
    bus.if_req_addr  = ifA;
    bus.ls_req_valid = lsV;
    bus.ls_req_addr  = lsA;
    bus.ls_req_we    = lsWe;
    bus.ls_req_wdata = lsWd;
    bus.ls_req_size  = size_e'(lsSize[1:0]);
    bus.ls_req_sext  = lsSext;

    gIf = 1'b0;
    gLs = 1'b0;
    if (rstLow) begin
      lastAddr   = '0;
      lastOffset = '0;
      lastWdata  = '0;
      lastByte1  = 1'b0;
      lastUpper  = 1'b0;
      sinceReset = 1'b1;
      rspQ.delete();
`ifdef MEM_ARB_FAIRNESS_EN
      starve = 0;
`endif
    end else begin
`ifdef MEM_ARB_FAIRNESS_EN
      forced = (starve == STARVE);
`else
      forced = 1'b0;
`endif
      gLs = lsV && !(ifV && forced);
      gIf = ifV && !gLs;
`ifdef MEM_ARB_FAIRNESS_EN
      if (!ifV || gIf) starve = 0;
      else if (gLs && starve < 7) starve++;
`endif
    end

    a         = gLs ? lsA : ifA;
    size      = gLs ? lsSize : 2;
    inRange   = (a < MEM_SIZE);
    e.rspZero = sinceReset;
    if (gIf || gLs) begin
      lastAddr   = a;
      lastOffset = a + 32'd4;
      lastByte1  = (size != 0);
      lastUpper  = (size == 2);
      if (gLs) lastWdata = lsWd;
      sinceReset = 1'b0;
      if (gIf || !lsWe || !inRange) begin
        r.cycle = drvCycle + 1;
        r.isIf  = gIf;
        r.byte1 = lastByte1;
        r.upper = lastUpper;
        r.sext  = gLs && lsSext;
        r.err   = !inRange;
        rspQ.push_back(r);
      end
    end
    e.ifRdy    = gIf;
    e.lsRdy    = gLs;
    e.clkEn    = gIf || gLs;
    e.we       = gLs && lsWe && inRange;
    e.byte1    = lastByte1;
    e.upper    = lastUpper;
    e.addr     = lastAddr;
    e.offset   = lastOffset;
    e.wdata    = lastWdata;
    e.chkWdata = gLs;
    issueQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(0, 0, '0, 0, '0, 0, '0, 0, 0);
  endtask

  // Monitor: compares issue-stage outputs every cycle and responses whenever the DUT raises one
  initial begin : monitor
    issue_t e;
    rsp_t   r;
    forever begin
      @(negedge clk);
      #2;
      if (issueQ.size() != 0) begin
        e = issueQ.pop_front();
        checkOutput("if_req_ready", bus.if_req_ready, e.ifRdy);
        checkOutput("ls_req_ready", bus.ls_req_ready, e.lsRdy);
        checkOutput("mem_clk_enable", bus.mem_clk_enable, e.clkEn);
        checkOutput("mem_we", bus.mem_we, e.we);
        checkOutput("mem_addr", bus.mem_addr, e.addr);
        checkOutput("mem_offset_addr", bus.mem_offset_addr, e.offset);
        checkOutput("mem_byte1_en", bus.mem_byte1_en, e.byte1);
        checkOutput("mem_upper_en", bus.mem_upper_en, e.upper);
        if (e.chkWdata) checkOutput("mem_wdata", bus.mem_wdata, e.wdata);
        if (e.rspZero) begin
          checkOutput("rsp_byte1_en_quiet", bus.rsp_byte1_en, 0);
          checkOutput("rsp_upper_en_quiet", bus.rsp_upper_en, 0);
          checkOutput("rsp_sext_quiet", bus.rsp_sext, 0);
          checkOutput("rsp_err_quiet", bus.rsp_err, 0);
        end
      end
      while (rspQ.size() != 0 && rspQ[0].cycle < drvCycle) begin
        r = rspQ.pop_front();
        total++;
        bad++;
        $display("[TB] FAIL rsp_missing: got no response, expected one in cycle %0d", r.cycle);
      end
      if (bus.if_rsp_valid || bus.ls_rsp_valid) begin
        if (rspQ.size() == 0 || rspQ[0].cycle != drvCycle) begin
          total++;
          bad++;
          $display("[TB] FAIL rsp_unexpected at cycle %0d: got if=%0b ls=%0b, expected no response",
                   drvCycle, bus.if_rsp_valid, bus.ls_rsp_valid);
        end else begin
          r = rspQ.pop_front();
          checkOutput("if_rsp_valid", bus.if_rsp_valid, r.isIf);
          checkOutput("ls_rsp_valid", bus.ls_rsp_valid, !r.isIf);
          checkOutput("rsp_byte1_en", bus.rsp_byte1_en, r.byte1);
          checkOutput("rsp_upper_en", bus.rsp_upper_en, r.upper);
          checkOutput("rsp_sext", bus.rsp_sext, r.sext);
          checkOutput("rsp_err", bus.rsp_err, r.err);
        end
      end
    end
  end

  // Driver: reset, directed scenarios, then randomized traffic with a mid-run reset
  initial begin : driver
    bit          rs;
    bit          ifV;
    bit          lsV;
    bit          we;
    bit          sx;
    int          sz;
    logic [31:0] ia;
    logic [31:0] la;
    logic [31:0] wd;
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = '0;
    bus.ls_req_valid = 1'b0;
    bus.ls_req_addr  = '0;
    bus.ls_req_we    = 1'b0;
    bus.ls_req_wdata = '0;
    bus.ls_req_size  = BYTE;
    bus.ls_req_sext  = 1'b0;

    // requests waving during reset must not get through
    repeat (3) applyStimulus(1, 1, 32'h40, 1, 32'h44, 0, 32'h1234, 2, 1);
    idle();
    // IF alone
    applyStimulus(0, 1, 32'h10, 0, '0, 0, '0, 0, 0);
    idle();
    // contested: LS half load with sign extension wins
    applyStimulus(0, 1, 32'h20, 1, 32'h102, 0, '0, 1, 1);
    // byte store at the top of memory: no response
    applyStimulus(0, 0, '0, 1, 32'h7FE, 1, 32'hAB, 0, 0);
    // out-of-range load and store
    applyStimulus(0, 0, '0, 1, 32'h800, 0, '0, 2, 0);
    applyStimulus(0, 0, '0, 1, 32'h900, 1, 32'hDEADBEEF, 2, 0);
    // misaligned fetch wrapping past the end
    applyStimulus(0, 1, 32'h7FF, 0, '0, 0, '0, 0, 0);
    idle();
    // sustained contention
    repeat (12) applyStimulus(0, 1, 32'h100, 1, 32'h200, 0, '0, 2, 0);
    idle();
    // reset right after an IF grant drops its response
    applyStimulus(0, 1, 32'h30, 0, '0, 0, '0, 0, 0);
    applyStimulus(1, 1, 32'h34, 0, '0, 0, '0, 0, 0);
    applyStimulus(1, 0, '0, 0, '0, 0, '0, 0, 0);
    repeat (3) idle();
    applyStimulus(0, 1, 32'h38, 0, '0, 0, '0, 0, 0);
    idle();

    for (int i = 0; i < 400; i++) begin
      rs  = (i == 200) || (i == 201);
      ifV = ($urandom_range(0, 3) != 0);
      lsV = ($urandom_range(0, 1) != 0);
      ia  = $urandom();
      la  = $urandom();
      if ($urandom_range(0, 7) != 0) ia = ia & 32'h7FF;
      if ($urandom_range(0, 7) != 0) la = la & 32'h7FF;
      we  = ($urandom_range(0, 2) == 0);
      wd  = $urandom();
      sz  = $urandom_range(0, 2);
      sx  = ($urandom_range(0, 1) != 0);
      applyStimulus(rs, ifV, ia, lsV, la, we, wd, sz, sx);
    end
    repeat (2) idle();

    @(negedge clk);
    #4;
    checkOutput("rsp_queue_drained", rspQ.size(), 0);
    checkOutput("issue_queue_drained", issueQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
